csa_accumulator: RTL and testbench

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

---
 rtl/csa_accumulator_if.sv | 24 ++
 rtl/csa_accumulator.sv | 100 ++++++++++
 tb/tb_csa_accumulator.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/csa_accumulator_if.sv
// rtl/csa_accumulator_if.sv - operand/result handshake bundle for the carry-save accumulator
interface csa_accumulator_if #(
    parameter int OP_W  = 4,
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  x;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;
    logic             ovf;

    modport master (
        output in_valid, x, flush, out_ready,
        input  in_ready, out_valid, result, ovf
    );

    modport slave (
        input  in_valid, x, flush, out_ready,
        output in_ready, out_valid, result, ovf
    );
endinterface

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - carry-save operand accumulator with bit-serial resolve and sticky overflow
module csa_accumulator #(
    parameter int OP_W  = 4,
    parameter int ACC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    csa_accumulator_if.slave   bus
);
    localparam int IDX_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;

    typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;

    state_t           state;
    logic [ACC_W-1:0] s;
    logic [ACC_W-1:0] c;
    logic [ACC_W-1:0] res;
    logic             cy;
    logic             ovf_st;
    logic [IDX_W-1:0] idx;
    logic             out_valid_q;
    logic [ACC_W-1:0] result_q;
    logic             ovf_q;

    logic [ACC_W-1:0] xe;
    logic [ACC_W-1:0] m;
    logic             accept;
    logic             bit_sum;
    logic             bit_cy;

    assign xe      = {{(ACC_W-OP_W){1'b0}}, bus.x};
    assign m       = (s & c) | (s & xe) | (c & xe);
    assign accept  = bus.in_valid && (state == ACCUM);
    assign bit_sum = s[idx] ^ c[idx] ^ cy;
    assign bit_cy  = (s[idx] & c[idx]) | (s[idx] & cy) | (c[idx] & cy);

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            s           <= '0;
            c           <= '0;
            res         <= '0;
            cy          <= 1'b0;
            ovf_st      <= 1'b0;
            idx         <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        s      <= s ^ c ^ xe;
                        // A majority bit shifted out of the top is exactly one lost 2^ACC_W.
                        c      <= {m[ACC_W-2:0], 1'b0};
                        ovf_st <= ovf_st | m[ACC_W-1];
                        if (bus.flush) begin
                            state <= RESOLVE;
                            idx   <= '0;
                            cy    <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    res[idx] <= bit_sum;
                    cy       <= bit_cy;
                    idx      <= idx + 1'b1;
                    if (idx == IDX_W'(ACC_W-1)) begin
                        ovf_st <= ovf_st | bit_cy;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle loads the output registers; handshake starts once valid.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        result_q    <= res;
                        ovf_q       <= ovf_st;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        result_q    <= '0;
                        ovf_q       <= 1'b0;
                        s           <= '0;
                        c           <= '0;
                        res         <= '0;
                        ovf_st      <= 1'b0;
                        cy          <= 1'b0;
                        state       <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - randomized self-checking bench for csa_accumulator
module tb_csa_accumulator;
    localparam int OP_W  = 4;
    localparam int ACC_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   opq[$];

    csa_accumulator_if #(.OP_W(OP_W), .ACC_W(ACC_W)) bus ();

    csa_accumulator #(.OP_W(OP_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int val, input bit last, input int gap);
        bit ok;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.x        = OP_W'(val);
        bus.flush    = last;
        for (int k = 0; k < 100; k++) begin
            ok = bus.in_ready;
            tick();
            if (ok) return;
        end
        check("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_ops(input int max_gap, output int sum);
        sum = 0;
        foreach (opq[k]) begin
            sum += opq[k];
            send_beat(opq[k], k == opq.size() - 1, (max_gap > 0) ? $urandom_range(max_gap, 0) : 0);
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic collect(input string tag, input int sum, input bit chk_lat, input int hold);
        int lat;
        logic [ACC_W-1:0] exp_res;
        bit exp_ovf;
        exp_res = ACC_W'(sum % (1 << ACC_W));
        exp_ovf = (sum >= (1 << ACC_W));
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        if (chk_lat) check({tag, "_latency"}, lat, ACC_W + 1);
        check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = h[0];
            bus.x        = OP_W'($urandom);
            bus.flush    = 1'b1;
            tick();
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_result"}, 32'(bus.result), 32'(exp_res));
            check({tag, "_hold_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_post_result"}, 32'(bus.result), 32'd0);
        check({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_set(input string tag, input int max_gap, input bit chk_lat, input int hold);
        int sum;
        send_ops(max_gap, sum);
        collect(tag, sum, chk_lat, hold);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_result"}, 32'(bus.result), 32'd0);
        check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
    endtask

    initial begin
        int sum;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check_reset_state("reset");
        rst_n = 1'b1;
        tick();
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);

        opq = '{3, 5, 7};
        run_set("set_3_5_7", 0, 1'b1, 0);

        opq = {};
        repeat (17) opq.push_back(15);
        run_set("set_17x15", 0, 1'b1, 0);
        opq.push_back(15);
        run_set("set_18x15", 0, 1'b0, 0);

        opq = '{0};
        run_set("single_0", 0, 1'b1, 0);
        opq = '{9};
        run_set("single_9", 0, 1'b0, 0);

        opq = '{6, 11, 4};
        run_set("hold5", 0, 1'b0, 5);
        opq = '{1};
        run_set("after_hold", 0, 1'b0, 0);

        opq = '{5, 6};
        send_ops(0, sum);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_resolve");
        tick();
        rst_n = 1'b1;
        tick();
        opq = '{2, 2};
        run_set("after_rst_resolve", 0, 1'b0, 0);

        opq = '{15, 15, 15};
        send_ops(0, sum);
        repeat (12) tick();
        check("rst_done_pre_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_done");
        tick();
        rst_n = 1'b1;
        tick();
        opq = '{2, 2};
        run_set("after_rst_done", 1, 1'b0, 0);

        for (int t = 0; t < 30; t++) begin
            int n;
            n = $urandom_range(40, 1);
            opq = {};
            for (int k = 0; k < n; k++) opq.push_back($urandom_range(15, 0));
            run_set($sformatf("rand%0d", t), $urandom_range(2, 0), 1'b0, $urandom_range(3, 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
